ppm_symbol_serializer: RTL

PPM_SYMBOL_SERIALIZER -- requirements
Module: ppm_symbol_serializer

---
 rtl/ppm_tx_pkg.sv | 20 ++
 rtl/ppm_symbol_serializer.sv | 97 +++++++++
 2 files changed

// File: rtl/ppm_tx_pkg.sv
// Shared definitions for the PPM transmit path: serializer FSM encoding and
// symbol-count / index-width derivation.
package ppm_tx_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } ser_state_t;

   function automatic int calc_nsym(input int data_w, input int sym_w);
      return data_w / sym_w;
   endfunction

   // Width stays at least 1 so a degenerate NSYM still elaborates far enough
   // to reach the parameter check in the serializer.
   function automatic int calc_idx_w(input int nsym);
      return (nsym < 2) ? 1 : $clog2(nsym);
   endfunction

endpackage

// File: rtl/ppm_symbol_serializer.sv
// Splits DATA_W-bit words into SYM_W-bit symbols with valid/ready on both sides.
// The held word is never shifted; an index selects the outgoing symbol.
module ppm_symbol_serializer
   import ppm_tx_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int SYM_W     = 2,
   parameter int MSB_FIRST = 0,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              sym_valid,
   input  logic              sym_ready,
   output logic [SYM_W-1:0]  sym_data,
   output logic              sym_first,
   output logic              sym_last,
   output logic              busy,
   output logic [CNT_W-1:0]  word_cnt
);

   localparam int NSYM  = calc_nsym(DATA_W, SYM_W);
   localparam int IDX_W = calc_idx_w(NSYM);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSYM - 1);

   if ((DATA_W % SYM_W) != 0) begin : g_bad_ratio
      $error("ppm_symbol_serializer: DATA_W must be a multiple of SYM_W");
   end
   if (NSYM < 2) begin : g_bad_nsym
      $error("ppm_symbol_serializer: need at least two symbols per word");
   end

   ser_state_t                   state_q, state_d;
   logic [NSYM-1:0][SYM_W-1:0]   word_q, word_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [IDX_W-1:0]             sel;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic                         consume, last_take, load;

   assign sym_valid = (state_q == ST_SHIFT);
   assign busy      = (state_q == ST_SHIFT);
   assign sym_first = sym_valid & (idx_q == '0);
   assign sym_last  = sym_valid & (idx_q == IDX_LAST);
   assign consume   = sym_valid & sym_ready;
   assign last_take = consume & sym_last;
   assign in_ready  = ~rst & ~flush & ((state_q == ST_IDLE) | last_take);
   assign load      = in_valid & in_ready;
   assign word_cnt  = cnt_q;

   assign sel      = (MSB_FIRST != 0) ? (IDX_LAST - idx_q) : idx_q;
   assign sym_data = sym_valid ? word_q[sel] : '0;

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      if (flush) begin
         // A symbol taken in the flush cycle is dropped, not counted.
         state_d = ST_IDLE;
         idx_d   = '0;
      end else begin
         if (last_take) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         if (load) begin
            state_d = ST_SHIFT;
            word_d  = in_data;
            idx_d   = '0;
         end else if (last_take) begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end else if (consume) begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         word_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
